// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Serves MULT/MULTU/DIV/DIVU (multi-cycle) and MFHI/MFLO/MTHI/MTLO.
// One operand bit is processed per clock; the result is sign-corrected in FIX.
// Optional feature macro: MULT_DIV_DIV_ZERO_TRAP_EN
//   defined   - div_zero port exists; DIV/DIVU by zero goes straight to DONE
//               with div_zero=1 and leaves hi/lo untouched.
//   undefined - divide by zero runs at full latency giving lo=all ones, hi=a.
module mult_div_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
`else
    output logic [WIDTH-1:0] lo
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // Latched operation context
    logic [1:0]         op_r;
    logic               sign_a_r;
    logic               sign_b_r;
    logic               b_zero_r;
    logic [WIDTH-1:0]   opnd_r;      // multiplicand (mult) or divisor (div)
    logic [2*WIDTH-1:0] acc;         // {upper, lower} working register
    logic [CNT_W-1:0]   cnt;

    // Operand decode
    logic               accept;
    logic               signed_op;
    logic               is_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               b_is_zero;
    logic               trap_hit;

    // Iteration step results
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Start acceptance and operand magnitude extraction
    always_comb begin
        accept    = start && (state == S_IDLE || state == S_DONE);
        signed_op = ~op[0];
        is_div    = op[1];
        mag_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
        b_is_zero = (b == '0);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
        trap_hit  = accept && is_div && b_is_zero;
`else
        trap_hit  = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_next = trap_hit ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (accept) state_next = trap_hit ? S_DONE : S_CALC;
                else        state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_r} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_r};
        if (!div_diff[WIDTH]) div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                  div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction; a zero divisor keeps the all-ones quotient un-negated
    // while the remainder (=|a|) re-acquires a's sign, giving hi=a.
    always_comb begin
        prod_fix = (!op_r[0] && (sign_a_r ^ sign_b_r)) ? (~acc + 1'b1) : acc;
        quot_fix = (!op_r[0] && (sign_a_r ^ sign_b_r) && !b_zero_r)
                   ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = (!op_r[0] && sign_a_r)
                   ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Datapath: operand latch, iteration, result and MTHI/MTLO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= '0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            b_zero_r <= 1'b0;
            opnd_r   <= '0;
            acc      <= '0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (accept && !trap_hit) begin
                op_r     <= op;
                sign_a_r <= signed_op && a[WIDTH-1];
                sign_b_r <= signed_op && b[WIDTH-1];
                b_zero_r <= b_is_zero;
                opnd_r   <= is_div ? mag_b : mag_a;
                acc      <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
                cnt      <= '0;
            end else if (state == S_CALC) begin
                acc <= op_r[1] ? div_next : mul_next;
                cnt <= cnt + CNT_W'(1);
            end

            if (state == S_FIX) begin
                if (op_r[1]) begin
                    hi <= rem_fix;
                    lo <= quot_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if (!busy && !start) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
    // Divide-by-zero flag, high only in the DONE cycle that follows a trap
    always_ff @(posedge clk) begin
        if (reset) div_zero <= 1'b0;
        else       div_zero <= trap_hit;
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
    logic         div_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
        .lo      (lo),
        .div_zero(div_zero)
`else
        .lo      (lo)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; issues one start pulse, scrambles inputs after the
    // start edge, then waits (bounded) for done. Returns at the done negedge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output int bc, output int wc, output bit to);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = ~o; a = ~va; b = ~vb;
        bc = 0; wc = 0; to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            if (busy) bc++;
            wc++;
            @(negedge clk);
        end
    endtask

    int bc, wc, dcount;
    bit to;

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
        check("rst_div_zero", div_zero, 0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // MULT -3 * 7
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, bc, wc, to);
        check("mult_timeout", to, 0);
        check("mult_busy_cycles", bc, 33);
        check("mult_latency", wc, 33);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
        check("mult_div_zero", div_zero, 0);
`endif
        @(negedge clk);
        check("mult_done_single", done, 0);
        check("mult_busy_after", busy, 0);
        check("mult_hold_lo", lo, 32'hFFFFFFEB);

        // MULTU max * max
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, wc, to);
        check("multu_timeout", to, 0);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        @(negedge clk);

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, bc, wc, to);
        check("div_timeout", to, 0);
        check("div_latency", wc, 33);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        @(negedge clk);

        // DIV MIN_NEG / -1
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, bc, wc, to);
        check("divovf_timeout", to, 0);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);
        @(negedge clk);

        // DIVU 7 / 2
        run_op(2'b11, 32'h00000007, 32'h00000002, bc, wc, to);
        check("divu_timeout", to, 0);
        check("divu_lo", lo, 32'h00000003);
        check("divu_hi", hi, 32'h00000001);
        @(negedge clk);

        // DIVU by zero
        run_op(2'b11, 32'h12345678, 32'h00000000, bc, wc, to);
        check("div0_timeout", to, 0);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
        check("div0_latency", wc, 0);
        check("div0_flag", div_zero, 1);
        check("div0_lo_kept", lo, 32'h00000003);
        check("div0_hi_kept", hi, 32'h00000001);
        @(negedge clk);
        check("div0_flag_clear", div_zero, 0);
`else
        check("div0_latency", wc, 33);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'h12345678);
        @(negedge clk);
`endif

        // MTHI/MTLO while idle
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_hi", hi, 32'hA5A5A5A5);
        check("mt_lo", lo, 32'hA5A5A5A5);
        lo_we = 1'b1; wdata = 32'h0000BEEF;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_only_lo", lo, 32'h0000BEEF);
        check("mtlo_only_hi", hi, 32'hA5A5A5A5);

        // Start dropped-write: start wins over a simultaneous MTHI
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'h0;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("startprio_hi", hi, 32'hA5A5A5A5);
        // While busy: MTHI and a new start are both ignored
        hi_we = 1'b1; wdata = 32'h0; start = 1'b1; a = 32'd7; b = 32'd9;
        @(negedge clk);
        hi_we = 1'b0; start = 1'b0;
        check("busy_mthi_ignored", hi, 32'hA5A5A5A5);
        wc = 2; to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            wc++;
            @(negedge clk);
        end
        check("busyign_timeout", to, 0);
        check("busyign_latency", wc, 34);
        check("busyign_hi", hi, 32'h0);
        check("busyign_lo", lo, 32'h6);
        @(negedge clk);

        // Reset mid-operation at CALC edge 10
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("abort_no_done", dcount, 0);

        run_op(2'b00, 32'd5, 32'd5, bc, wc, to);
        check("after_abort_timeout", to, 0);
        check("after_abort_lo", lo, 32'h00000019);
        check("after_abort_hi", hi, 32'h0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers. It serves the multi-cycle CPU's MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO instructions.
- The controller issues a start pulse, stalls in a wait state while busy=1, and resumes on done.
- Operand width is parametrised.
- Divide-by-zero optionally raises an error into the existing Err/EPC exception path.

Parameters:
- WIDTH, 32, operand width and HI/LO register width; must be ≥4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request operation; accepted only when busy=0
- op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)
- div_zero  out  1  divide-by-zero flag; only present with DIV_ZERO_TRAP_EN

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
- State machine: IDLE, CALC, FIX, DONE.
- IDLE or DONE with start=1 at edge N:
  - Latch op, operand signs and operand magnitudes (absolute values for signed ops; raw values for unsigned ops).
  - Clear the accumulator and counter, then enter CALC.
- DONE with start=0: return to IDLE on the next edge.
- CALC: one bit per edge for exactly WIDTH edges (N+1..N+WIDTH).
  - Multiply: shift-add on a 2*WIDTH product.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
- FIX: single edge (N+WIDTH+1).
  - Apply sign correction.
  - Write hi/lo, then enter DONE.
- Timing:
  - busy=1 from after edge N through edge N+WIDTH+1.
  - done=1 and new hi/lo are visible during the cycle after edge N+WIDTH+1 (a single cycle).
  - Total latency is WIDTH+1 edges after the start edge (33 for WIDTH=32).
- Signed multiply: product is negated when sign(a)^sign(b). hi:lo = full 2*WIDTH-bit two's-complement product.
- Signed divide rules:
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a); truncation toward zero.
  - MIN_NEG / -1 gives lo=MIN_NEG (wrap) and hi=0, with no error.
- Divide by zero (macro off): lo = all ones, hi = a; done is asserted normally, with normal latency.
- start while busy=1: ignored. The operands and op of the running operation are unaffected.
- hi_we/lo_we:
  - When busy=0 and start=0, write wdata on that edge; both may be written in the same cycle.
  - Ignored while busy=1.
  - If start=1 in the same cycle, start takes priority and the writes are dropped.
- hi/lo hold their values between operations; they are modified only at FIX, by MTHI/MTLO, or by reset.
- reset asserted mid-operation (any state): abort immediately, all outputs go to reset values, and no done pulse is produced.
- Operands a, b and op may change after the start edge without effect.

Optional Feature:
- Macro: MULT_DIV_DIV_ZERO_TRAP_EN
- Defined:
  - The div_zero port exists.
  - DIV/DIVU with b=0 skips CALC: the start edge goes directly to DONE.
  - done=1 and div_zero=1 together for one cycle; hi/lo are left unchanged.
  - The controller uses div_zero as an Err source.
  - div_zero=0 in all other cycles.
- Undefined:
  - No div_zero port.
  - Divide by zero behaves as specified above (lo=all ones, hi=a, full latency).

Test Plan (WIDTH=32):
- MULT a=FFFFFFFD (−3), b=00000007 → after 33 edges: done pulse, hi=FFFFFFFF, lo=FFFFFFEB; busy high for exactly 33 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- Divide cases:
  - DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
  - DIVU a=7, b=2 → lo=3, hi=1.
  - DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- DIVU a=12345678, b=0:
  - Macro off: lo=FFFFFFFF, hi=12345678 after 33 edges.
  - Macro on: prior hi/lo preserved; done=div_zero=1 one edge after start.
- MTHI/MTLO and busy handling:
  - In IDLE, hi_we=lo_we=1 with wdata=A5A5A5A5 → hi=lo=A5A5A5A5.
  - Start MULT 2×3, then during busy pulse hi_we with wdata=0 and start with new operands → both ignored; result hi=0, lo=6.
- Start MULT 5×5, assert reset at CALC edge 10 → next cycle busy=0, done=0, hi=lo=0; no done pulse thereafter. A subsequent MULT 5×5 completes normally with lo=19.
